// File: rtl/conv_row_engine.sv
// Streaming 1-D convolution row engine: TAPS-wide sliding window MAC with bias,
// optional partial-sum input and a selectable ReLU / raw / ReLU+truncate post-stage.
module conv_row_engine #(
   parameter int DATA_BITS     = 16,
   parameter int INTERNAL_BITS = 32,
   parameter int TAPS          = 3,
   parameter int FRAC_BITS     = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_load,
   input  logic [DATA_BITS-1:0]     w_data,
   output logic                     w_ready,
   input  logic                     bias_load,
   input  logic [DATA_BITS-1:0]     bias_data,
   input  logic [1:0]               cfg_mode,
   input  logic                     psum_en,
   input  logic [INTERNAL_BITS-1:0] psum_in,
   input  logic                     if_valid,
   output logic                     if_ready,
   input  logic [DATA_BITS-1:0]     if_data,
   input  logic                     if_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INTERNAL_BITS-1:0] out_data,
   output logic                     busy
);

   localparam int CNT_W = $clog2(TAPS + 1);
   localparam logic [INTERNAL_BITS-1:0] SAT_MAX =
      {{(INTERNAL_BITS-DATA_BITS+1){1'b0}}, {(DATA_BITS-1){1'b1}}};

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                              r_state, w_state_nxt;
   logic [TAPS-1:0][DATA_BITS-1:0]      r_w, r_x, w_xn;
   logic [DATA_BITS-1:0]                r_bias;
   logic [CNT_W-1:0]                    r_cnt, w_cnt_inc;
   logic [INTERNAL_BITS-1:0]            r_out;
   logic                                r_ovld;
   logic                                w_accept, w_complete;
   logic signed [2*DATA_BITS-1:0]       w_prod;
   logic signed [INTERNAL_BITS-1:0]     w_acc;
   logic [INTERNAL_BITS-1:0]            w_relu, w_shift, w_post;

   // Single output register: a pop frees the slot for a new beat in the same cycle.
   assign if_ready   = !r_ovld || out_ready;
   assign w_accept   = if_valid && if_ready;
   assign w_cnt_inc  = (r_cnt == CNT_W'(TAPS)) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_complete = w_accept && (w_cnt_inc == CNT_W'(TAPS));
   assign out_valid  = r_ovld;
   assign out_data   = r_out;

   always_comb begin
      w_xn = r_x;
      for (int k = 0; k < TAPS - 1; k++) w_xn[k] = r_x[k+1];
      w_xn[TAPS-1] = if_data;
   end

   always_comb begin
      w_prod = '0;
      w_acc  = INTERNAL_BITS'($signed(r_bias));
      if (psum_en) w_acc = w_acc + $signed(psum_in);
      for (int k = 0; k < TAPS; k++) begin
         w_prod = $signed(r_w[k]) * $signed(w_xn[k]);
         w_acc  = w_acc + INTERNAL_BITS'(w_prod);
      end
   end

   always_comb begin
      w_relu  = w_acc[INTERNAL_BITS-1] ? '0 : w_acc;
      w_shift = w_relu >> FRAC_BITS;
      case (cfg_mode)
         2'b00:   w_post = w_relu;
         2'b10:   w_post = (w_shift > SAT_MAX) ? SAT_MAX : w_shift;
         default: w_post = w_acc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w    <= '0;
         r_bias <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_load) begin
            for (int k = 0; k < TAPS - 1; k++) r_w[k] <= r_w[k+1];
            r_w[TAPS-1] <= w_data;
         end
         if (bias_load) r_bias <= bias_data;
      end
   end

   // if_last clears the window after its own result has been formed from w_xn.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x   <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         if (if_last) begin
            r_x   <= '0;
            r_cnt <= '0;
         end else begin
            r_x   <= w_xn;
            r_cnt <= w_cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out  <= '0;
         r_ovld <= 1'b0;
      end else if (w_complete) begin
         r_out  <= w_post;
         r_ovld <= 1'b1;
      end else if (out_ready) begin
         r_ovld <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Inside STREAM, cnt==0 only occurs after an if_last beat.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (w_accept) w_state_nxt = S_STREAM;
         end
         S_STREAM: begin
            busy = 1'b1;
            if (r_cnt == '0 && !r_ovld && !w_accept) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_row_engine.sv
// Directed bench for conv_row_engine: table of row vectors plus hand-written
// stall, short-row, weight-lock and mid-row reset sequences.
module tb_conv_row_engine;

   logic        clk = 0;
   logic        rst;
   logic        w_load, bias_load, w_ready;
   logic [15:0] w_data, bias_data;
   logic [1:0]  cfg_mode;
   logic        psum_en;
   logic [31:0] psum_in;
   logic        if_valid, if_ready, if_last;
   logic [15:0] if_data;
   logic        out_valid, out_ready, busy;
   logic [31:0] out_data;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] q[$];

   conv_row_engine #(.DATA_BITS(16), .INTERNAL_BITS(32), .TAPS(3), .FRAC_BITS(8)) dut (
      .clk(clk), .rst(rst),
      .w_load(w_load), .w_data(w_data), .w_ready(w_ready),
      .bias_load(bias_load), .bias_data(bias_data),
      .cfg_mode(cfg_mode), .psum_en(psum_en), .psum_in(psum_in),
      .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data), .if_last(if_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && out_valid && out_ready) q.push_back(out_data);

   typedef struct {
      logic [15:0] w0, w1, w2, bias;
      logic [1:0]  mode;
      logic        pen;
      logic [31:0] psum;
      logic [15:0] x0, x1, x2, x3;
      int          nx;
      int          nout;
      logic [31:0] e0, e1;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input string nm);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (w_ready) begin ok = 1; break; end
      end
      chk(nm, {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic load_w(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] bs);
      w_load = 1; w_data = a; @(posedge clk); #1;
      w_data = b; @(posedge clk); #1;
      w_data = c; @(posedge clk); #1;
      w_load = 0;
      bias_load = 1; bias_data = bs; @(posedge clk); #1;
      bias_load = 0;
   endtask

   task automatic drive_beat(input logic [15:0] d, input logic last, input logic [31:0] ps);
      bit ok = 0;
      if_valid = 1; if_data = d; if_last = last; psum_in = ps;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (if_ready) begin ok = 1; break; end
      end
      if (ok) begin @(posedge clk); #1; end
      else chk("beat_accept_timeout", 32'd0, 32'd1);
      if_valid = 0; if_last = 0;
   endtask

   function automatic logic [15:0] pick(input vec_t v, input int i);
      case (i)
         0: return v.x0;
         1: return v.x1;
         2: return v.x2;
         default: return v.x3;
      endcase
   endfunction

   initial begin
      rst = 1; w_load = 0; bias_load = 0; w_data = 0; bias_data = 0;
      cfg_mode = 2'b01; psum_en = 0; psum_in = 0;
      if_valid = 0; if_data = 0; if_last = 0; out_ready = 1;

      vt[0] = '{16'd1, 16'd2, 16'd3, 16'd0, 2'b01, 1'b0, 32'd0, 16'd1, 16'd2, 16'd3, 16'd4, 4, 2, 32'd14, 32'd20};
      vt[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 2'b00, 1'b0, 32'd0, 16'd5, 16'd5, 16'd5, 16'd0, 3, 1, 32'd0, 32'd0};
      vt[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 2'b01, 1'b0, 32'd0, 16'd5, 16'd5, 16'd5, 16'd0, 3, 1, 32'hFFFFFFF1, 32'd0};
      vt[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd20, 2'b00, 1'b0, 32'd0, 16'd5, 16'd5, 16'd5, 16'd0, 3, 1, 32'd5, 32'd0};
      vt[4] = '{16'd1, 16'd0, 16'd0, 16'd0, 2'b10, 1'b0, 32'd0, 16'h1234, 16'd0, 16'd0, 16'd0, 3, 1, 32'h12, 32'd0};
      vt[5] = '{16'd1, 16'd0, 16'd0, 16'd0, 2'b10, 1'b1, 32'h7FFF0000, 16'd0, 16'd0, 16'd0, 16'd0, 3, 1, 32'h7FFF, 32'd0};
      vt[6] = '{16'd1, 16'd2, 16'd3, 16'd0, 2'b01, 1'b1, 32'd100, 16'd1, 16'd2, 16'd3, 16'd4, 4, 2, 32'd114, 32'd120};
      vt[7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 2'b11, 1'b0, 32'd0, 16'd5, 16'd5, 16'd5, 16'd0, 3, 1, 32'hFFFFFFF1, 32'd0};
      vt[8] = '{16'd1, 16'd2, 16'd3, 16'd0, 2'b00, 1'b0, 32'd0, 16'd1, 16'd2, 16'd3, 16'd4, 4, 2, 32'd14, 32'd20};
      vt[9] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 2'b10, 1'b0, 32'd0, 16'd5, 16'd5, 16'd5, 16'd0, 3, 1, 32'd0, 32'd0};

      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_w_ready", {31'd0, w_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
      @(posedge clk); #1; rst = 0;

      foreach (vt[n]) begin
         wait_idle($sformatf("v%0d_idle", n));
         load_w(vt[n].w0, vt[n].w1, vt[n].w2, vt[n].bias);
         cfg_mode = vt[n].mode; psum_en = vt[n].pen; out_ready = 1;
         q.delete();
         for (int i = 0; i < vt[n].nx; i++)
            drive_beat(pick(vt[n], i), i == vt[n].nx - 1, (i >= 2) ? vt[n].psum : 32'd999);
         repeat (4) @(posedge clk); #1;
         chk($sformatf("v%0d_count", n), q.size(), vt[n].nout);
         if (q.size() > 0) chk($sformatf("v%0d_out0", n), q[0], vt[n].e0);
         if (vt[n].nout > 1 && q.size() > 1) chk($sformatf("v%0d_out1", n), q[1], vt[n].e1);
      end
      psum_en = 0;

      // Backpressure: result stalls, if_ready drops, release pops and accepts together.
      wait_idle("stall_idle");
      load_w(16'd1, 16'd2, 16'd3, 16'd0);
      cfg_mode = 2'b01; out_ready = 0; q.delete();
      drive_beat(16'd1, 0, 0);
      drive_beat(16'd2, 0, 0);
      chk("lat_pre", {31'd0, out_valid}, 32'd0);
      drive_beat(16'd3, 0, 0);
      chk("lat_post", {31'd0, out_valid}, 32'd1);
      chk("lat_data", out_data, 32'd14);
      chk("stream_busy", {31'd0, busy}, 32'd1);
      if_valid = 1; if_data = 16'd4; if_last = 1;
      repeat (3) @(negedge clk);
      chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
      chk("stall_hold", out_data, 32'd14);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1; out_ready = 1;
      @(negedge clk);
      chk("release_if_ready", {31'd0, if_ready}, 32'd1);
      @(posedge clk); #1; if_valid = 0; if_last = 0;
      chk("release_valid", {31'd0, out_valid}, 32'd1);
      chk("release_data", out_data, 32'd20);
      wait_idle("stall_drain_idle");
      chk("stall_busy_off", {31'd0, busy}, 32'd0);
      chk("stall_count", q.size(), 2);
      if (q.size() == 2) begin
         chk("stall_q0", q[0], 32'd14);
         chk("stall_q1", q[1], 32'd20);
      end

      // Short row gives nothing; loads during STREAM are ignored.
      q.delete();
      drive_beat(16'd1, 0, 0);
      drive_beat(16'd2, 1, 0);
      repeat (4) @(posedge clk); #1;
      chk("short_row_count", q.size(), 0);
      wait_idle("short_idle");
      drive_beat(16'd1, 0, 0);
      chk("lock_w_ready", {31'd0, w_ready}, 32'd0);
      w_load = 1; w_data = 16'd9; bias_load = 1; bias_data = 16'd50;
      repeat (3) @(posedge clk); #1;
      w_load = 0; bias_load = 0;
      drive_beat(16'd2, 0, 0);
      drive_beat(16'd3, 1, 0);
      repeat (4) @(posedge clk); #1;
      chk("lock_count", q.size(), 1);
      if (q.size() > 0) chk("lock_out", q[0], 32'd14);

      // Reset with a result pending, then confirm weights were cleared.
      wait_idle("rst_row_idle");
      out_ready = 0; q.delete();
      drive_beat(16'd1, 0, 0);
      drive_beat(16'd2, 0, 0);
      drive_beat(16'd3, 0, 0);
      chk("pend_valid", {31'd0, out_valid}, 32'd1);
      rst = 1; #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_w_ready", {31'd0, w_ready}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      @(posedge clk); #1; rst = 0; out_ready = 1;
      bias_load = 1; bias_data = 16'd7; @(posedge clk); #1; bias_load = 0;
      drive_beat(16'd1, 0, 0);
      drive_beat(16'd2, 0, 0);
      drive_beat(16'd3, 1, 0);
      repeat (4) @(posedge clk); #1;
      chk("post_rst_count", q.size(), 1);
      if (q.size() > 0) chk("post_rst_out", q[0], 32'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
